intmatmul_host_driver: RTL
==========================

Name: intmatmul_host_driver

Overview:
- Bus-master sequencer that drives the slave side of the integer matrix-multiply benchmark bus (RD/WR/Addr/DataIn/DataOut) in scan mode.
- Streams pVectorSize² matrix words to Addr 0, then pVectorSize vector words to Addr 1, waits for the dot products to settle, then reads results from Addr 0..pVectorSize-1.
- Sits between a word-stream source/sink (testbench or on-chip host) and the matmul control block.

Parameters:
- pVectorSize, 4, vector length N; matrix is N×N.
- pWordSize, 8, element and result width W.
- pSettle, 2, idle cycles between the last vector write and the first read (≥2; the slave needs 1 cycle for input regs and 1 for the dot-product reg).
- pAddrWidth, 15, bus address width.
- pDataWidth, 32, bus data width.

Ports:
- Clk  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a transaction; ignored unless idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last result is accepted.
- in_valid  in  1  source word valid.
- in_data  in  W  source word: N² matrix words, then N vector words.
- in_ready  out  1  high only in LOAD_M/LOAD_V.
- out_valid  out  1  result valid.
- out_data  out  W  result word k = dot product k mod 2^W.
- out_index  out  clog2(N)  index k of out_data.
- out_ready  in  1  sink accepts the result.
- RD  out  1  bus read strobe.
- WR  out  1  bus write strobe.
- Addr  out  pAddrWidth  bus address.
- BusDataOut  out  pDataWidth  write data, connected to the slave DataIn.
- BusDataIn  in  pDataWidth  read data, from the slave DataOut.

Behaviour:
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, out_index=0, RD=0, WR=0, Addr=0, BusDataOut=0. State is IDLE and all counters are 0. Reset has priority in every state and aborts a transaction mid-flight; no bus strobe is issued on the following cycle.
- IDLE:
  - start=1 → LOAD_M with cnt=0.
  - start in any other state is ignored.
- LOAD_M:
  - in_ready=1.
  - On each in_valid&in_ready cycle, register WR=1, Addr=0, BusDataOut={zero-extend, in_data} for exactly one cycle.
  - Otherwise WR=0.
  - After the N²-th word, go to LOAD_V with cnt=0.
  - Word j ends at slave matrix slot j, because the slave shift register moves toward index 0.
- LOAD_V: same as LOAD_M with Addr=1 and N words; then go to SETTLE.
- SETTLE:
  - RD=0, WR=0.
  - Count pSettle cycles, counted from the cycle after the last WR pulse, then go to RD_ISSUE with k=0.
- RD_ISSUE: RD=1, Addr=k for one cycle. The slave loads its holder register on this edge. Next state is RD_HOLD.
- RD_HOLD:
  - RD=1, Addr=k held.
  - Capture BusDataIn[W-1:0] into out_data, set out_index=k and out_valid=1.
  - Drop RD next cycle and go to OUT_WAIT.
- OUT_WAIT:
  - out_valid stays high, with data held stable, until out_ready.
  - On acceptance: if k==N-1, go to DONE; otherwise k++ and go to RD_ISSUE.
  - out_ready while out_valid=0 has no effect.
- DONE: done=1 for one cycle, then IDLE; busy drops in the same cycle.
- Exclusivity: RD and WR are never high in the same cycle. Addr changes only when the next strobe is issued.
- Arithmetic: none is performed locally. Results are the slave's modulo-2^W sums, passed through unmodified.
- Stalls: in_valid low stalls the load indefinitely with no WR pulse. Stalls keep slave ordering intact.

Decomposition:
- Shared package intmatmul_pkg holds:
  - the state enum (IDLE, LOAD_M, LOAD_V, SETTLE, RD_ISSUE, RD_HOLD, OUT_WAIT, DONE);
  - bus address constants ADDR_MATRIX=0 and ADDR_VECTOR=1;
  - a clog2 helper function.
- Single module. The word counter and settle counter share one register; no sub-module is warranted.

Test Plan:
- Identity matrix with vector [1,2,3,4], N=4, W=8, paired with the real slave → out_data 1,2,3,4 with out_index 0..3, then a done pulse. Exactly 16 WRs at Addr 0 and 4 at Addr 1.
- All elements 255 → every result equals 4·(255·255) mod 256 = 4.
- in_valid toggling every other cycle, plus out_ready held low 5 cycles per result → identical results. WR count is unchanged. out_data stays stable while stalled.
- Reset asserted after the 7th matrix word, then a new full transaction → correct results for the new data. The stale partial load must have no effect once 16 fresh words have been shifted in.
- start pulsed during LOAD_V and during OUT_WAIT → ignored; busy stays high and exactly one done pulse occurs.
- Protocol monitor: RD&WR never both high. At least pSettle idle cycles between the last WR and the first RD. Each read keeps RD high for exactly 2 cycles at a constant Addr.

Source files
------------

// File: rtl/intmatmul_pkg.sv
// Shared definitions for the integer matrix-multiply host driver: sequencer
// states, slave bus address map and a constant-width helper.
package intmatmul_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_M   = 3'd1,
    LOAD_V   = 3'd2,
    SETTLE   = 3'd3,
    RD_ISSUE = 3'd4,
    RD_HOLD  = 3'd5,
    OUT_WAIT = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam int ADDR_MATRIX = 0;
  localparam int ADDR_VECTOR = 1;

  // Ceiling log2 for elaboration-time widths; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/intmatmul_host_driver.sv
// Bus-master sequencer: streams an NxN matrix and an N vector into the matmul
// slave, waits for the dot products to settle, then reads the N results back.
module intmatmul_host_driver
  import intmatmul_pkg::*;
#(
  parameter int pVectorSize = 4,
  parameter int pWordSize   = 8,
  parameter int pSettle     = 2,
  parameter int pAddrWidth  = 15,
  parameter int pDataWidth  = 32,
  localparam int pIdxWidth  = (clog2(pVectorSize) > 0) ? clog2(pVectorSize) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  input  logic [pWordSize-1:0]  in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [pWordSize-1:0]  out_data,
  output logic [pIdxWidth-1:0]  out_index,
  input  logic                  out_ready,
  output logic                  RD,
  output logic                  WR,
  output logic [pAddrWidth-1:0] Addr,
  output logic [pDataWidth-1:0] BusDataOut,
  input  logic [pDataWidth-1:0] BusDataIn
);

  localparam int NumMatrix = pVectorSize * pVectorSize;
  localparam int CntMax    = (NumMatrix > pSettle) ? NumMatrix : pSettle;
  localparam int CntWidth  = clog2(CntMax + 1);

  state_t                state;
  logic [CntWidth-1:0]   cnt;       // word counter while loading, settle counter afterwards
  logic [pIdxWidth-1:0]  resultIdx;
  logic                  inAccept;

  assign in_ready = (state == LOAD_M) || (state == LOAD_V);
  assign inAccept = in_ready && in_valid;
  assign busy     = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);

  // Only the low result word is meaningful; the slave zero-fills the rest.
  generate
    if (pDataWidth > pWordSize) begin : g_busHigh
      logic unusedBusHigh;
      assign unusedBusHigh = ^BusDataIn[pDataWidth-1:pWordSize];
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resultIdx  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      RD         <= 1'b0;
      WR         <= 1'b0;
      Addr       <= '0;
      BusDataOut <= '0;
    end else begin
      WR <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_M;
            cnt   <= '0;
          end
        end

        LOAD_M: begin
          if (inAccept) begin
            WR         <= 1'b1;
            Addr       <= pAddrWidth'(ADDR_MATRIX);
            BusDataOut <= pDataWidth'(in_data);
            if (cnt == CntWidth'(NumMatrix - 1)) begin
              cnt   <= '0;
              state <= LOAD_V;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        LOAD_V: begin
          if (inAccept) begin
            WR         <= 1'b1;
            Addr       <= pAddrWidth'(ADDR_VECTOR);
            BusDataOut <= pDataWidth'(in_data);
            if (cnt == CntWidth'(pVectorSize - 1)) begin
              cnt   <= '0;
              state <= SETTLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        // The first SETTLE cycle carries the last WR pulse, so waiting until
        // cnt reaches pSettle leaves exactly pSettle idle cycles before RD.
        SETTLE: begin
          if (cnt == CntWidth'(pSettle)) begin
            cnt       <= '0;
            resultIdx <= '0;
            RD        <= 1'b1;
            Addr      <= '0;
            state     <= RD_ISSUE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RD_ISSUE: begin
          state <= RD_HOLD;
        end

        RD_HOLD: begin
          RD        <= 1'b0;
          out_data  <= BusDataIn[pWordSize-1:0];
          out_index <= resultIdx;
          out_valid <= 1'b1;
          state     <= OUT_WAIT;
        end

        OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (resultIdx == pIdxWidth'(pVectorSize - 1)) begin
              state <= DONE;
            end else begin
              resultIdx <= resultIdx + 1'b1;
              RD        <= 1'b1;
              Addr      <= pAddrWidth'(resultIdx + 1'b1);
              state     <= RD_ISSUE;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
